// File: rtl/fft_pkg.sv
// Constants and sample type shared by the FFT front end, the FFT core and the twiddle blocks.
package fft_pkg;

    localparam int BIT_WIDTH  = 32;
    localparam int DECIMAL_PT = 16;
    localparam int N_SAMPLES  = 8;

    typedef logic [BIT_WIDTH-1:0] sample_t;

endpackage

// File: rtl/frame_bank.sv
// One frame of sample storage with an indexed write port and a full flag.
module frame_bank
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = fft_pkg::BIT_WIDTH,
    parameter int N_SAMPLES = fft_pkg::N_SAMPLES,
    localparam int IDX_W    = $clog2(N_SAMPLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [BIT_WIDTH-1:0] wr_data,
    input  logic                 set_full,
    input  logic                 clr_full,
    output logic                 full,
    output logic [BIT_WIDTH-1:0] data [N_SAMPLES-1:0]
);

    // set and clear never target the same bank in one edge, so set simply wins
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                data[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                data[wr_idx] <= wr_data;
            end
            if (set_full) begin
                full <= 1'b1;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_sample_deserializer.sv
// Collects N_SAMPLES serial samples into a parallel frame for the FFT.
// Define DESERIALIZER_PINGPONG_EN for two ping-pong banks; otherwise a single bank is built.
module serial_sample_deserializer
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = fft_pkg::BIT_WIDTH,
    parameter int N_SAMPLES = fft_pkg::N_SAMPLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0],
    output logic                 send_val,
    input  logic                 send_rdy
);

    localparam int IDX_W = $clog2(N_SAMPLES);

    logic [IDX_W-1:0]     widx;
    logic                 recv_fire;
    logic                 send_fire;
    logic                 frame_done;
    logic                 wbank;
    logic                 rbank;
    logic                 full_w;
    logic                 full_r;
    logic                 full0;
    logic [BIT_WIDTH-1:0] data0 [N_SAMPLES-1:0];

    assign recv_rdy   = !full_w && !reset;
    assign send_val   = full_r;
    assign recv_fire  = recv_val && recv_rdy;
    assign send_fire  = send_val && send_rdy;
    assign frame_done = recv_fire && (widx == IDX_W'(N_SAMPLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            widx <= '0;
        end else if (frame_done) begin
            widx <= '0;
        end else if (recv_fire) begin
            widx <= widx + 1'b1;
        end
    end

    frame_bank #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_SAMPLES (N_SAMPLES)
    ) bank0 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (recv_fire && !wbank),
        .wr_idx   (widx),
        .wr_data  (recv_msg),
        .set_full (frame_done && !wbank),
        .clr_full (send_fire && !rbank),
        .full     (full0),
        .data     (data0)
    );

`ifdef DESERIALIZER_PINGPONG_EN
    logic                 full1;
    logic [BIT_WIDTH-1:0] data1 [N_SAMPLES-1:0];

    frame_bank #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_SAMPLES (N_SAMPLES)
    ) bank1 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (recv_fire && wbank),
        .wr_idx   (widx),
        .wr_data  (recv_msg),
        .set_full (frame_done && wbank),
        .clr_full (send_fire && rbank),
        .full     (full1),
        .data     (data1)
    );

    // Write and read pointers advance independently, so capture overlaps readout
    always_ff @(posedge clk) begin
        if (reset) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
        end else begin
            if (frame_done) begin
                wbank <= ~wbank;
            end
            if (send_fire) begin
                rbank <= ~rbank;
            end
        end
    end

    assign full_w = wbank ? full1 : full0;
    assign full_r = rbank ? full1 : full0;

    always_comb begin
        for (int i = 0; i < N_SAMPLES; i++) begin
            send_msg[i] = rbank ? data1[i] : data0[i];
        end
    end
`else
    assign wbank    = 1'b0;
    assign rbank    = 1'b0;
    assign full_w   = full0;
    assign full_r   = full0;
    assign send_msg = data0;
`endif

endmodule

// File: tb/tb_serial_sample_deserializer.sv
// Scoreboard bench for serial_sample_deserializer; follows DESERIALIZER_PINGPONG_EN like the RTL.
module tb_serial_sample_deserializer;

    localparam int W = 32;
    localparam int N = 8;
`ifdef DESERIALIZER_PINGPONG_EN
    localparam int CAP         = 2;
    localparam int STREAM_CYCS = 64;
`else
    localparam int CAP         = 1;
    localparam int STREAM_CYCS = 71;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] recv_msg = '0;
    logic         recv_val = 1'b0;
    logic         recv_rdy;
    logic [W-1:0] send_msg [N-1:0];
    logic         send_val;
    logic         send_rdy = 1'b0;

    int checks = 0;
    int errors = 0;
    int frames_out = 0;
    bit mon_en = 1'b0;

    logic [N*W-1:0] exp_q [$];
    logic [W-1:0]   partial [$];

    serial_sample_deserializer #(.BIT_WIDTH(W), .N_SAMPLES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare on the falling edge, then account for the fires of the coming rising edge
    always @(negedge clk) begin
        logic           exp_val;
        logic           exp_rdy;
        logic [N*W-1:0] f;
        if (mon_en) begin
            exp_val = (exp_q.size() != 0);
            exp_rdy = !reset && (exp_q.size() < CAP);
            checks++;
            if (send_val !== exp_val) begin
                errors++;
                $display("[TB] FAIL send_val_model: got %b expected %b at %0t", send_val, exp_val, $time);
            end
            checks++;
            if (recv_rdy !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL recv_rdy_model: got %b expected %b at %0t", recv_rdy, exp_rdy, $time);
            end
            if (exp_val && send_val === 1'b1) begin
                checks++;
                for (int i = 0; i < N; i++) begin
                    if (send_msg[i] !== exp_q[0][i*W +: W]) begin
                        errors++;
                        $display("[TB] FAIL frame_word[%0d]: got %h expected %h at %0t",
                                 i, send_msg[i], exp_q[0][i*W +: W], $time);
                        break;
                    end
                end
            end
            if (reset) begin
                exp_q.delete();
                partial.delete();
            end else begin
                if (send_val === 1'b1 && send_rdy && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    frames_out++;
                end
                if (recv_val && recv_rdy === 1'b1) begin
                    partial.push_back(recv_msg);
                    if (partial.size() == N) begin
                        for (int i = 0; i < N; i++) f[i*W +: W] = partial[i];
                        exp_q.push_back(f);
                        partial.delete();
                    end
                end
            end
        end
    end

    // Presents one sample until accepted; called and returns at 1 time unit after a rising edge
    task automatic drive_sample(input logic [W-1:0] d);
        logic acc;
        acc = 1'b0;
        recv_val = 1'b1;
        recv_msg = d;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = recv_rdy;
            @(posedge clk);
            #1;
        end
        recv_val = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: sample %h not accepted, required accept within 200 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if (recv_rdy !== 1'b0 || send_val !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake: rdy=%b val=%b expected 0/0", recv_rdy, send_val);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (send_msg[i] !== '0) begin
                errors++;
                $display("[TB] FAIL reset_msg[%0d]: got %h expected 0", i, send_msg[i]);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (recv_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rdy_after_reset: got %b expected 1", recv_rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int f0;
        f0 = frames_out;
        send_rdy = 1'b1;
        for (int i = 0; i < N; i++) drive_sample(32'h0001_0000 * (i + 1));
        @(negedge clk);
        checks++;
        if (send_val !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_latency: send_val=%b expected 1", send_val);
        end
        checks++;
        if (send_msg[0] !== 32'h0001_0000 || send_msg[7] !== 32'h0008_0000) begin
            errors++;
            $display("[TB] FAIL basic_ends: got %h/%h expected 00010000/00080000", send_msg[0], send_msg[7]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (send_val !== 1'b0 || frames_out - f0 != 1) begin
            errors++;
            $display("[TB] FAIL basic_once: send_val=%b frames=%0d expected 0 and 1", send_val, frames_out - f0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int cnt;
        int f0;
        cnt = 0;
        f0 = frames_out;
        send_rdy = 1'b0;
        for (int c = 0; c < 24; c++) begin
            recv_val = 1'b1;
            recv_msg = 32'h0000_0200 + cnt;
            @(negedge clk);
            if (recv_rdy) cnt++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (cnt != CAP * N || recv_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_accepts: accepted %0d rdy=%b expected %0d and 0", cnt, recv_rdy, CAP * N);
        end
        recv_val = 1'b0;
        send_rdy = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (recv_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release: rdy=%b expected 1 after first send", recv_rdy);
        end
        @(posedge clk);
        #1;
        idle(4);
        checks++;
        if (frames_out - f0 != CAP || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL stall_drain: frames %0d pending %0d expected %0d and 0",
                     frames_out - f0, exp_q.size(), CAP);
        end
    endtask

    task automatic test_stream();
        int cnt;
        int cyc;
        int f0;
        cnt = 0;
        cyc = 0;
        f0 = frames_out;
        send_rdy = 1'b1;
        while (cnt < 64 && cyc < 200) begin
            recv_val = 1'b1;
            recv_msg = 32'h000B_0000 + cnt;
            @(negedge clk);
            if (recv_rdy) cnt++;
            cyc++;
            @(posedge clk);
            #1;
        end
        recv_val = 1'b0;
        checks++;
        if (cyc != STREAM_CYCS) begin
            errors++;
            $display("[TB] FAIL stream_cycles: took %0d cycles expected %0d", cyc, STREAM_CYCS);
        end
        idle(3);
        checks++;
        if (frames_out - f0 != 8) begin
            errors++;
            $display("[TB] FAIL stream_frames: got %0d expected 8", frames_out - f0);
        end
    endtask

    task automatic test_gaps();
        int cnt;
        int f0;
        cnt = 0;
        f0 = frames_out;
        for (int c = 0; c < 400 && cnt < 24; c++) begin
            recv_val = 1'($urandom_range(1));
            recv_msg = 32'h0000_A000 + cnt;
            send_rdy = 1'($urandom_range(1));
            @(negedge clk);
            if (recv_val && recv_rdy) cnt++;
            @(posedge clk);
            #1;
        end
        recv_val = 1'b0;
        send_rdy = 1'b1;
        idle(4);
        checks++;
        if (cnt != 24 || frames_out - f0 != 3 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL gaps_frames: accepted %0d frames %0d pending %0d expected 24/3/0",
                     cnt, frames_out - f0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        send_rdy = 1'b1;
        for (int i = 0; i < 5; i++) drive_sample(32'h000C_0000 + i);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (send_val !== 1'b0 || recv_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_state: val=%b rdy=%b expected 0/0", send_val, recv_rdy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        f0 = frames_out;
        for (int i = 0; i < N; i++) drive_sample(32'h000D_0000 + i);
        idle(2);
        checks++;
        if (frames_out - f0 != 1) begin
            errors++;
            $display("[TB] FAIL midreset_frame: frames %0d expected 1", frames_out - f0);
        end
    endtask

    task automatic test_back_to_back();
        int f0;
        f0 = frames_out;
        send_rdy = 1'b0;
        for (int i = 0; i < N; i++) drive_sample(32'h000E_0000 + i);
`ifdef DESERIALIZER_PINGPONG_EN
        for (int i = 0; i < N - 1; i++) drive_sample(32'h000F_0000 + i);
        recv_val = 1'b1;
        recv_msg = 32'h000F_0000 + N - 1;
        send_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (send_val !== 1'b1 || recv_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collide_fires: val=%b rdy=%b expected 1/1", send_val, recv_rdy);
        end
        @(posedge clk);
        #1;
        recv_val = 1'b0;
        idle(3);
        checks++;
        if (frames_out - f0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL collide_frames: frames %0d pending %0d expected 2/0", frames_out - f0, exp_q.size());
        end
`else
        @(negedge clk);
        checks++;
        if (send_val !== 1'b1 || recv_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_hold: val=%b rdy=%b expected 1/0", send_val, recv_rdy);
        end
        @(posedge clk);
        #1;
        send_rdy = 1'b1;
        idle(3);
        checks++;
        if (frames_out - f0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_frames: frames %0d pending %0d expected 1/0", frames_out - f0, exp_q.size());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_stream();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
